// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial byte receiver.
//   rx_state_t : FSM encoding (IDLE=0, SHIFT=1, PARITY=2)
//   count_w()  : bit-counter width for a given frame width, $clog2(w+1)
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rx_shift_core.sv
// Shift register with per-frame latched direction.
//   clk      : rising-edge clock
//   clr      : synchronous clear of shift reg and latched direction
//   shift_en : shift bit_in into the register this edge
//   first    : this shift is the first bit of a frame; dir is taken live and latched
//   bit_in   : serial data bit
//   dir      : 1 = LSB-first, 0 = MSB-first
//   word     : value the register holds after this edge (post-shift when shift_en=1)
module rx_shift_core
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             first,
  input  logic             bit_in,
  input  logic             dir,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             dir_q;
  logic             eff_dir;

  // The first bit of a frame must use the live direction input since the
  // latched copy is only written on that same edge.
  always_comb begin
    eff_dir = first ? dir : dir_q;
    if (eff_dir) begin
      sr_next = {bit_in, sr[WIDTH-1:1]};
    end else begin
      sr_next = {sr[WIDTH-2:0], bit_in};
    end
    word = shift_en ? sr_next : sr;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr    <= '0;
      dir_q <= 1'b0;
    end else if (shift_en) begin
      sr <= sr_next;
      if (first) begin
        dir_q <= dir;
      end
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel receiver with a 1-deep valid/ready holding register.
// Optional feature macro: SBRX_PARITY_EN (adds an even-parity bit per frame
// and the parity_err output).
//   clk        : rising-edge clock
//   clr        : synchronous active-high reset, highest priority
//   bit_in     : serial data bit, sampled when bit_valid=1
//   bit_valid  : bit qualifier
//   lsb_first  : frame bit order, latched on the first bit of each frame
//   abort      : drop partial frame, return to IDLE (holding reg untouched)
//   out_data   : received word
//   out_valid  : holding register full
//   out_ready  : consumer accepts when out_valid & out_ready
//   busy       : frame in progress
//   overrun    : sticky, a completed word was dropped
//   parity_err : (SBRX_PARITY_EN only) parity of held word, qualified by out_valid
//   dbg_state  : current FSM state
//
// Handshake: a word transfers on any edge where out_valid & out_ready are both
// 1. out_data is held stable while out_valid=1 and out_ready=0; a word that
// completes in that condition is discarded and overrun is set.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             lsb_first,
  input  logic             abort,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SBRX_PARITY_EN
  output logic             parity_err,
`endif
  output rx_state_t        dbg_state
);

  localparam int CW = count_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SBRX_PARITY_EN
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
`endif

  rx_state_t        state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             shift_en;
  logic             first;
  logic             complete;
  logic [WIDTH-1:0] word;

  rx_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clr      (clr | abort),
    .shift_en (shift_en),
    .first    (first),
    .bit_in   (bit_in),
    .dir      (lsb_first),
    .word     (word)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    shift_en = 1'b0;
    first    = 1'b0;
    complete = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid) begin
            shift_en = 1'b1;
            first    = 1'b1;
            cnt_d    = CW'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            shift_en = 1'b1;
            if (cnt == LAST) begin
`ifdef SBRX_PARITY_EN
              state_d = PARITY;
              cnt_d   = FULL;
`else
              complete = 1'b1;
              state_d  = IDLE;
              cnt_d    = '0;
`endif
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
        end
`ifdef SBRX_PARITY_EN
        PARITY: begin
          // The data word sits unshifted in the core; this bit only ends the frame.
          if (bit_valid) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SBRX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (complete) begin
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else begin
        out_data   <= word;
        out_valid  <= 1'b1;
`ifdef SBRX_PARITY_EN
        parity_err <= ^{word, bit_in};
`endif
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
